// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions,
// handshake FSM encoding and the opcode classifier used by the top.
// Optional divider: build with ALU_SEQ_DIV_EN defined to enable opcode 0111.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_LSL = 4'b0100;
  localparam logic [3:0] OP_LSR = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_EOR = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes that run on the iterative engine rather than the one-cycle datapath.
  function automatic logic is_iterative(input logic [3:0] op_code);
`ifdef ALU_SEQ_DIV_EN
    return (op_code == OP_MUL) || (op_code == OP_DIV);
`else
    return (op_code == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: unsigned shift-add multiplier retiring MUL_STEP bits per
// cycle, plus a restoring divider when ALU_SEQ_DIV_EN is defined.
// Operands load on start; a down-counter runs the iterations and done is the
// terminal count while busy.
module alu_seq_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import alu_seq_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH / MUL_STEP);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
  logic [WIDTH-1:0] opa;   // shifted multiplicand / quotient shift register
  logic [WIDTH-1:0] opb;   // multiplier shifted down / divisor
  logic [WIDTH-1:0] mul_acc;

  // One multiplier step: add the multiplicand for each set low multiplier bit.
  always_comb begin
    mul_acc = acc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (opb[i]) mul_acc = mul_acc + (opa << i);
    end
  end

`ifdef ALU_SEQ_DIV_EN
  localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);
  logic             div_q;
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  // One restoring-divide step; the remainder always fits WIDTH bits after subtract.
  always_comb begin
    r_sh  = {acc, opa[WIDTH-1]};
    r_ge  = (r_sh >= {1'b0, opb});
    rem_n = r_ge ? (r_sh[WIDTH-1:0] - opb) : r_sh[WIDTH-1:0];
    quo_n = {opa[WIDTH-2:0], r_ge};
  end

  assign result = div_q ? opa : acc;
`else
  assign result = acc;
`endif

  assign done = busy && (cnt == '0);

  // Operand load on start, then one iteration per cycle until the counter expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      opa  <= '0;
      opb  <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      acc  <= '0;
      opa  <= a;
      opb  <= b;
`ifdef ALU_SEQ_DIV_EN
      div_q <= is_div;
      cnt   <= is_div ? DIV_CNT : MUL_CNT;
`else
      cnt   <= MUL_CNT;
`endif
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
          acc <= rem_n;
          opa <= quo_n;
        end else begin
          acc <= mul_acc;
          opa <= opa << MUL_STEP;
          opb <= opb >> MUL_STEP;
        end
`else
        acc <= mul_acc;
        opa <= opa << MUL_STEP;
        opb <= opb >> MUL_STEP;
`endif
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: valid/ready handshake FSM, single-cycle datapath,
// iterative MUL/DIV engine and registered result/NZCV flags.
// Optional divider: define ALU_SEQ_DIV_EN; otherwise opcode 0111 is illegal.
//
// state   | meaning
// IDLE    | ready for a request; in_ready high
// EXEC    | operands captured; one cycle, or until the engine finishes
// DONE    | out_valid high; result/flags held until out_ready
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import alu_seq_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept, load_out;
  logic             eng_start, eng_busy, eng_done;
  logic [WIDTH-1:0] eng_result;
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             shift_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flg;

  assign in_ready  = (state == ST_IDLE) && !eng_busy;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign eng_start = accept && is_iterative(op);

  alu_seq_muldiv #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
`ifdef ALU_SEQ_DIV_EN
    .is_div (op == OP_DIV),
`endif
    .start  (eng_start),
    .a      (a),
    .b      (b),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and output-register load enable.
  always_comb begin
    state_n  = state;
    load_out = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_n = ST_EXEC;
      ST_EXEC: begin
        if (!is_iterative(op_q) || eng_done) begin
          load_out = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Capture the request on accept so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  assign sub_op    = (op_q == OP_SUB);
  assign b_eff     = sub_op ? ~b_q : b_q;
  assign sum       = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign shamt     = b_q[SHW-1:0];
  assign shift_big = |b_q[WIDTH-1:SHW];

  // Datapath result and flags for the captured opcode.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_ORR: alu_res = a_q | b_q;
      OP_EOR: alu_res = a_q ^ b_q;
      OP_LSL: alu_res = shift_big ? '0 : (a_q << shamt);
      OP_LSR: alu_res = shift_big ? '0 : (a_q >> shamt);
      OP_ASR: alu_res = shift_big ? {WIDTH{a_q[WIDTH-1]}} : $unsigned($signed(a_q) >>> shamt);
      OP_MUL: alu_res = eng_result;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        alu_res = eng_result;
        alu_v   = (b_q == '0);
      end
`endif
      default: alu_res = '0;
    endcase
    alu_flg         = '0;
    alu_flg[FLAG_N] = alu_res[WIDTH-1];
    alu_flg[FLAG_Z] = (alu_res == '0);
    alu_flg[FLAG_C] = alu_c;
    alu_flg[FLAG_V] = alu_v;
  end

  // Output registers; held through DONE until the consumer takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
    end else if (load_out) begin
      result <= alu_res;
      flags  <= alu_flg;
    end
  end

endmodule
